// File: rtl/imsic_pkg.sv
// Shared constants, CSR bundle type and topei formatting for the IMSIC interrupt file.
package imsic_pkg;

  // Indirect CSR selects
  localparam logic [7:0] EIDELIVERY  = 8'h70;
  localparam logic [7:0] EITHRESHOLD = 8'h72;
  localparam logic [7:0] EIP0        = 8'h80;
  localparam logic [7:0] EIE0        = 8'hC0;

  typedef struct packed {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
  } intp_file_csr_t;

  // topei carries the identity in both the identity and priority fields
  function automatic logic [31:0] topei_fmt(input logic [10:0] id);
    return {5'b0, id, 5'b0, id};
  endfunction

endpackage

// File: rtl/imsic_prio_encoder.sv
// Lowest-set-ID search over the candidate vector; 0 when nothing is set.
module imsic_prio_encoder #(
  parameter int NR_SRC = 64
) (
  input  logic [NR_SRC-1:0]         i_cand,
  output logic [$clog2(NR_SRC)-1:0] o_id
);
  localparam int SRC_W    = $clog2(NR_SRC);
  localparam int NR_WORDS = NR_SRC / 32;

  logic [NR_WORDS-1:0]      word_hit;
  logic [NR_WORDS-1:0][4:0] word_idx;

  // Stage A: lowest set bit inside every 32-bit word
  always_comb begin
    word_hit = '0;
    word_idx = '0;
    for (int w = 0; w < NR_WORDS; w++) begin
      word_hit[w] = |i_cand[w*32 +: 32];
      for (int b = 31; b >= 0; b--)
        if (i_cand[w*32 + b]) word_idx[w] = 5'(b);
    end
  end

  // Stage B: lowest non-empty word wins
  always_comb begin
    o_id = '0;
    for (int w = NR_WORDS - 1; w >= 0; w--)
      if (word_hit[w]) o_id = SRC_W'(w * 32 + int'(word_idx[w]));
  end

endmodule

// File: rtl/imsic_intp_file.sv
// One IMSIC interrupt file: eip/eie arrays, delivery/threshold, registered topei and irq.
module imsic_intp_file
  import imsic_pkg::*;
#(
  parameter int NR_SRC     = 64,
  parameter int NR_SRC_LEN = 32,
  parameter int SRC_W      = $clog2(NR_SRC),
  parameter int NR_WORDS   = NR_SRC / 32
) (
  input  logic                  i_clk,
  input  logic                  ni_rst,
  input  logic [NR_SRC_LEN-1:0] i_setipnum,
  input  logic                  i_setipnum_we,
  input  logic [7:0]            i_csr_addr,
  input  logic                  i_csr_we,
  input  logic [31:0]           i_csr_wdata,
  output logic [31:0]           o_csr_rdata,
  input  logic                  i_claim,
  output logic [31:0]           o_topei,
  output logic                  o_irq
);
  intp_file_csr_t    csr;
  logic [NR_SRC-1:0] eip_q, eip_d, eie_q, eie_d, cand;
  logic              eidelivery_q, eidelivery_d;
  logic [SRC_W-1:0]  eithreshold_q, eithreshold_d;
  logic [SRC_W-1:0]  topei_q, topei_d, prio_id;
  logic              stale_q, stale_d, irq_q, irq_d;
  logic [5:0]        word_sel;
  logic              word_ok, sel_eip, sel_eie, setip_ok, claim_ok;
  logic [SRC_W-1:0]  setip_id;

  assign csr      = '{addr: i_csr_addr, we: i_csr_we, wdata: i_csr_wdata};
  assign word_sel = csr.addr[5:0];
  assign word_ok  = int'(word_sel) < NR_WORDS;
  assign sel_eip  = (csr.addr[7:6] == EIP0[7:6]) && word_ok;
  assign sel_eie  = (csr.addr[7:6] == EIE0[7:6]) && word_ok;

  assign setip_ok = i_setipnum_we && (i_setipnum != '0)
                 && (i_setipnum < NR_SRC_LEN'(NR_SRC))
                 && (i_setipnum[NR_SRC_LEN-1:SRC_W] == '0);
  assign setip_id = i_setipnum[SRC_W-1:0];
  // A claim right after a state change may target an outdated topei, so it is dropped
  assign claim_ok = i_claim && (topei_q != '0) && !stale_q;

  // Candidate mask: pending, enabled and below threshold (threshold 0 disables the limit)
  always_comb begin
    cand = '0;
    for (int i = 0; i < NR_SRC; i++)
      cand[i] = eip_q[i] & eie_q[i] &
                ((eithreshold_q == '0) || (SRC_W'(i) < eithreshold_q));
  end

  imsic_prio_encoder #(.NR_SRC(NR_SRC)) u_prio (
    .i_cand (cand),
    .o_id   (prio_id)
  );

  // Next state: CSR write first, then claim clear, then setipnum set
  always_comb begin
    eip_d         = eip_q;
    eie_d         = eie_q;
    eidelivery_d  = eidelivery_q;
    eithreshold_d = eithreshold_q;
    if (csr.we) begin
      for (int k = 0; k < NR_WORDS; k++) begin
        if (sel_eip && word_sel == 6'(k)) eip_d[k*32 +: 32] = csr.wdata;
        if (sel_eie && word_sel == 6'(k)) eie_d[k*32 +: 32] = csr.wdata;
      end
      if (csr.addr == EIDELIVERY)  eidelivery_d  = csr.wdata[0];
      if (csr.addr == EITHRESHOLD) eithreshold_d = csr.wdata[SRC_W-1:0];
    end
    if (claim_ok) eip_d[topei_q]  = 1'b0;
    if (setip_ok) eip_d[setip_id] = 1'b1;
    eip_d[0] = 1'b0;
    eie_d[0] = 1'b0;
    stale_d  = claim_ok | (csr.we & (sel_eip | sel_eie |
               (csr.addr == EIDELIVERY) | (csr.addr == EITHRESHOLD)));
    topei_d  = prio_id;
    irq_d    = eidelivery_q & (prio_id != '0);
  end

  // State registers
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      eip_q         <= '0;
      eie_q         <= '0;
      eidelivery_q  <= 1'b0;
      eithreshold_q <= '0;
      topei_q       <= '0;
      stale_q       <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      eip_q         <= eip_d;
      eie_q         <= eie_d;
      eidelivery_q  <= eidelivery_d;
      eithreshold_q <= eithreshold_d;
      topei_q       <= topei_d;
      stale_q       <= stale_d;
      irq_q         <= irq_d;
    end
  end

  // Indirect CSR read mux; unimplemented selects read 0
  always_comb begin
    o_csr_rdata = '0;
    if (csr.addr == EIDELIVERY)  o_csr_rdata = {31'b0, eidelivery_q};
    if (csr.addr == EITHRESHOLD) o_csr_rdata = 32'(eithreshold_q);
    for (int k = 0; k < NR_WORDS; k++) begin
      if (sel_eip && word_sel == 6'(k)) o_csr_rdata = eip_q[k*32 +: 32];
      if (sel_eie && word_sel == 6'(k)) o_csr_rdata = eie_q[k*32 +: 32];
    end
  end

  assign o_topei = topei_fmt(11'(topei_q));
  assign o_irq   = irq_q;

endmodule

// File: doc/imsic_intp_file.md
Name: imsic_intp_file

Overview:
- One IMSIC interrupt file (M, S or VS level), directly downstream of the IMSIC register map.
- Consumes the per-file setipnum value/strobe, holds the eip/eie arrays plus eidelivery and eithreshold, and exposes them through an indirect-CSR port (iselect/ireg style).
- Computes topei through a registered priority search, supports claim, and drives the interrupt line to the hart.
- Instantiated NR_INTP_FILES times per IMSIC.

Parameters:
- NR_SRC, 64: number of interrupt identities including reserved ID 0; multiple of 32, range 32..2048.
- NR_SRC_LEN, 32: width of the incoming setipnum data.
- SRC_W, $clog2(NR_SRC): derived ID width; do not override.
- NR_WORDS, NR_SRC/32: derived eip/eie word count; do not override.

Ports:
- i_clk  in  1  clock.
- ni_rst  in  1  reset; asynchronous, active-low.
- i_setipnum  in  NR_SRC_LEN  identity to set pending.
- i_setipnum_we  in  1  setipnum strobe, one cycle per write.
- i_csr_addr  in  8  indirect select (0x70 eidelivery, 0x72 eithreshold, 0x80+k eip word k, 0xC0+k eie word k).
- i_csr_we  in  1  CSR write strobe.
- i_csr_wdata  in  32  CSR write data.
- o_csr_rdata  out  32  CSR read data; combinational from i_csr_addr.
- i_claim  in  1  topei claim strobe (write to *topei).
- o_topei  out  32  {5'b0, id[10:0], 5'b0, id[10:0]}; id zero-extended from SRC_W.
- o_irq  out  1  interrupt request to the hart.

Behaviour:
- Reset: eip, eie, eidelivery, eithreshold, the topei register, the stale flag and o_irq all 0; o_topei = 0.
- setipnum: when i_setipnum_we is high, 0 < i_setipnum < NR_SRC, and i_setipnum[NR_SRC_LEN-1:SRC_W] == 0, set eip[i_setipnum] at the next edge. Value 0 or out-of-range values are silently dropped.
- Bit 0 of eip word 0 and of eie word 0 is hardwired to 0.
- CSR writes:
  - eip/eie word k with k < NR_WORDS: full 32-bit replace.
  - eidelivery: only bit 0 is stored.
  - eithreshold: low SRC_W bits are stored.
  - All other addresses: write ignored, read returns 0.
  - Reads of unimplemented words return 0.
- Priority search: candidate = eip & eie & (thr==0 ? all : id<thr).
  - Stage A (combinational): per-word lowest set bit.
  - Stage B: lowest non-empty word.
  - Result registered into topei_q, so o_topei reflects state at edge N-1 (one-cycle latency).
  - The lowest ID has the highest priority.
- o_irq: registered; o_irq = eidelivery[0] & (next topei != 0). Same latency as o_topei.
- Claim: on i_claim with topei_q != 0 and stale == 0, clear eip[topei_q]. Claim when topei_q == 0 is a no-op.
- Stale flag: set for exactly one cycle following any event that can remove the current candidate:
  - a claim,
  - a CSR write to eip/eie/eithreshold,
  - a CSR write to eidelivery.
  - A claim while stale is ignored; software re-reads topei.
- Simultaneous events, in priority order:
  - setipnum for ID X together with a claim of X: the set wins and eip[X] stays 1.
  - setipnum together with a CSR eip write to the same word: the CSR value is applied first, then the setipnum bit is OR-ed in.
  - CSR write together with a claim: both are applied; the claim bit clear is applied after the CSR value.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous); no pending state survives.

Decomposition:
- imsic_pkg holds:
  - the CSR select constants (EIDELIVERY=8'h70, EITHRESHOLD=8'h72, EIP0=8'h80, EIE0=8'hC0);
  - the topei format helper function;
  - an intp_file_csr_t struct {addr, we, wdata} for the CSR bundle.
- One sub-module: imsic_prio_encoder (parameters NR_SRC; input candidate vector; output lowest set ID, 0 if none). Purely combinational; the parent owns the topei register.

Test Plan:
- Reset, then eidelivery=1, eie word0=32'hFFFF_FFFE, setipnum=5 -> one cycle later o_topei=32'h0005_0005 and o_irq=1; CSR read 0x80 returns 32'h20.
- Pend IDs 5 and 40 (eie all 1), claim -> eip[5] cleared; a claim in the next cycle is ignored (stale); o_topei=32'h0028_0028 after 1 cycle.
- eithreshold=10 with IDs 12 and 40 pending -> o_topei=0, o_irq=0; eithreshold=0 -> o_topei=32'h000C_000C.
- setipnum=0, setipnum=64 and setipnum=32'h1_0005 -> eip unchanged, reads of 0x80/0x81 return 0; setipnum=63 -> 0x81 reads 32'h8000_0000.
- Same cycle: setipnum=7, claim with topei_q=7 -> eip[7] stays 1; same cycle: CSR eip0 write 0 plus setipnum=3 -> eip0 reads 32'h8.
- Pend ID 9, then pulse ni_rst low mid-cycle -> o_irq and o_topei drop to 0 asynchronously; after release all CSR reads return 0.
